// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, reset defaults, opcode map and
// the fetch-stage state encoding.
package riscv_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_VALID = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   function automatic logic word_aligned(input logic [1:0] low_bits);
      return low_bits == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: async reset, redirect load (priority) or sequential +4,
// with a flag for a load of a non-word-aligned target.
module pc_reg #(
   parameter int               XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            incr,
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] pc,
   output logic            target_misaligned
);
   import riscv_pkg::*;

   assign target_misaligned = load && !word_aligned(target[1:0]);

   // +4 wraps naturally at the top of the address space.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= target;
      end else if (incr) begin
         pc <= pc + XLEN'(4);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight,
// buffers the returned word for decode, and handles stall/redirect/fault.
module fetch_unit #(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus4_out,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   output logic            misalign_fault
);
   import riscv_pkg::*;

   // Handshake: imem_req/imem_addr form a request held until imem_valid
   // (same cycle or later); a response returned after a redirect is
   // dropped. instr_valid/instr_out are consumed on any cycle with !stall.

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            pc_load;
   logic            pc_incr;
   logic            target_misaligned;
   logic            req_q;
   logic            valid_q;
   logic            fault_q;
   logic [31:0]     instr_q;

   assign pc_load = redirect && (state != ST_FAULT);
   assign pc_incr = (state == ST_VALID) && !stall;

   pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_reg (
      .clk               (clk),
      .rst               (rst),
      .load              (pc_load),
      .incr              (pc_incr),
      .target            (redirect_target),
      .pc                (pc),
      .target_misaligned (target_misaligned)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_FETCH;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         instr_q <= NOP;
      end else begin
         case (state)
            ST_FETCH: begin
               // req_q low means nothing is in flight yet (first cycle out of reset).
               if (redirect && target_misaligned) begin
                  state   <= ST_FAULT;
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
               end else if (redirect) begin
                  if (req_q && !imem_valid) begin
                     state <= ST_DRAIN;
                     req_q <= 1'b0;
                  end else begin
                     req_q <= 1'b1;
                  end
               end else if (req_q && imem_valid) begin
                  instr_q <= imem_rdata;
                  state   <= ST_VALID;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end else begin
                  req_q <= 1'b1;
               end
            end
            ST_VALID: begin
               if (redirect && target_misaligned) begin
                  state   <= ST_FAULT;
                  valid_q <= 1'b0;
                  fault_q <= 1'b1;
               end else if (redirect || !stall) begin
                  state   <= ST_FETCH;
                  req_q   <= 1'b1;
                  valid_q <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // A redirect arriving with the stale response can refetch at once.
               if (redirect && target_misaligned) begin
                  state   <= ST_FAULT;
                  fault_q <= 1'b1;
               end else if (imem_valid) begin
                  state <= ST_FETCH;
                  req_q <= 1'b1;
               end
            end
            ST_FAULT: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req       = req_q;
   assign imem_addr      = pc;
   assign instr_valid    = valid_q;
   assign instr_out      = instr_q;
   assign pc_out         = pc;
   assign pc_plus4_out   = pc + XLEN'(4);
   assign misalign_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against an architectural PC
// model and a latency-configurable instruction memory.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misalign_fault;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int IDLE_LIMIT = 15;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .misalign_fault  (misalign_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: lat_mode 0 = combinational, >0 fixed extra cycles, <0 random 1..3
  int          lat_mode;
  logic        busy;
  int          cnt;
  logic [31:0] lat_addr;
  int          req_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h4) return 32'h00a00113;
    return a ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (busy) begin
      if (cnt == 0) busy <= 1'b0;
      else cnt <= cnt - 1;
    end else if (imem_req) begin
      req_count <= req_count + 1;
      if (lat_mode != 0) begin
        busy     <= 1'b1;
        lat_addr <= imem_addr;
        cnt      <= ((lat_mode > 0) ? lat_mode : int'($urandom_range(1, 3))) - 1;
      end
    end
  end

  assign imem_valid = (lat_mode == 0) ? imem_req : (busy && cnt == 0);
  assign imem_rdata = mem_word((lat_mode == 0) ? imem_addr : lat_addr);

  // scoreboard state
  int          n_total;
  int          n_pass;
  int          n_fail;
  logic [31:0] model_pc;
  logic        exp_fault;
  logic        prev_hold;
  logic        prev_wait;
  int          idle;
  int          base_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_pc  = RESET_PC;
    exp_fault = 1'b0;
    prev_hold = 1'b0;
    prev_wait = 1'b0;
    idle      = 0;
  endtask

  // one cycle: check outputs against the model, drive inputs, advance model
  task automatic tick(input logic st, input logic rd, input logic [31:0] tgt);
    chk("fault_flag", misalign_fault, exp_fault);
    if (exp_fault) begin
      chk("fault_req", imem_req, 1'b0);
      chk("fault_valid", instr_valid, 1'b0);
    end else begin
      if (imem_req) begin
        chk("imem_addr", imem_addr, model_pc);
        chk("addr_align", imem_addr[1:0], 2'b00);
      end
      if (instr_valid) begin
        chk("pc_out", pc_out, model_pc);
        chk("instr_out", instr_out, mem_word(model_pc));
        chk("pc_plus4", pc_plus4_out, model_pc + 32'd4);
        idle = 0;
      end else begin
        idle++;
      end
      if (prev_hold) chk("stall_hold", instr_valid, 1'b1);
      if (prev_wait) chk("req_held", imem_req, 1'b1);
      chk("liveness", (idle > IDLE_LIMIT), 1'b0);
    end
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    prev_hold = instr_valid && st && !rd && !exp_fault;
    prev_wait = imem_req && !imem_valid && !rd && !exp_fault;
    if (!exp_fault) begin
      if (rd) begin
        model_pc = tgt;
        idle     = 0;
        if (tgt[1:0] != 2'b00) exp_fault = 1'b1;
      end else if (instr_valid && !st) begin
        model_pc = model_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!instr_valid && n < bound) begin
      tick(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("wait_valid", instr_valid, 1'b1);
  endtask

  task automatic do_reset(input int mode);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    #1;
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_fault", misalign_fault, 1'b0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    lat_mode = mode;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("req_before_edge", imem_req, 1'b0);
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    req_count = 0; lat_mode = 0; lat_addr = 32'h0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    model_reset();
    @(negedge clk);

    // combinational memory: first two instructions, then a 4-cycle stall
    do_reset(0);
    tick(1'b0, 1'b0, 32'h0);
    chk("c1_req", imem_req, 1'b1);
    chk("c1_valid", instr_valid, 1'b0);
    tick(1'b0, 1'b0, 32'h0);
    chk("c2_valid", instr_valid, 1'b1);
    chk("c2_pc", pc_out, 32'h0);
    chk("c2_pc4", pc_plus4_out, 32'h4);
    chk("c2_instr", instr_out, 32'h00500093);
    tick(1'b0, 1'b0, 32'h0);
    chk("c3_valid", instr_valid, 1'b0);
    chk("c3_addr", imem_addr, 32'h4);
    tick(1'b0, 1'b0, 32'h0);
    chk("c4_valid", instr_valid, 1'b1);
    chk("c4_pc", pc_out, 32'h4);
    chk("c4_pc4", pc_plus4_out, 32'h8);
    chk("c4_instr", instr_out, 32'h00a00113);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);
    chk("stall_valid", instr_valid, 1'b1);
    chk("stall_pc", pc_out, 32'h4);
    chk("stall_instr", instr_out, 32'h00a00113);
    tick(1'b0, 1'b0, 32'h0);
    chk("post_stall_addr", imem_addr, 32'h8);
    chk("post_stall_req", imem_req, 1'b1);

    // randomized traffic with combinational memory
    for (int i = 0; i < 60; i++)
      tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
           {22'h0, 8'($urandom_range(0, 255)), 2'b00});

    // async reset mid-operation
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc_out, RESET_PC);
    chk("async_rst_req", imem_req, 1'b0);
    @(negedge clk);

    // fixed 3-cycle memory: one request held, one delivery
    do_reset(2);
    base_req = req_count;
    tick(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("lat_req", imem_req, 1'b1);
      chk("lat_valid_low", instr_valid, 1'b0);
      tick(1'b0, 1'b0, 32'h0);
    end
    chk("lat_valid", instr_valid, 1'b1);
    chk("lat_instr", instr_out, 32'h00500093);
    chk("lat_one_req", req_count - base_req, 1);
    tick(1'b0, 1'b1, 32'h8);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h40);
    chk("drain_req", imem_req, 1'b0);
    chk("drain_addr", imem_addr, 32'h40);
    chk("drain_valid", instr_valid, 1'b0);
    tick(1'b0, 1'b0, 32'h0);
    wait_valid(12);
    chk("drain_first_pc", pc_out, 32'h40);
    chk("drain_first_instr", instr_out, mem_word(32'h40));

    // randomized traffic with random memory latency
    do_reset(-1);
    for (int i = 0; i < 80; i++)
      tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
           {22'h0, 8'($urandom_range(0, 255)), 2'b00});

    // PC wrap at the top of the address space
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_valid(15);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_out, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    begin
      int n = 0;
      while (!imem_req && n < 10) begin
        tick(1'b0, 1'b0, 32'h0);
        n++;
      end
    end
    chk("wrap_req", imem_req, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_no_fault", misalign_fault, 1'b0);

    // misaligned redirect: sticky fault until reset
    tick(1'b0, 1'b1, 32'h42);
    for (int i = 0; i < 8; i++) tick($urandom_range(0, 1), 1'b0, 32'h0);
    chk("fault_set", misalign_fault, 1'b1);
    chk("fault_pc", pc_out, 32'h42);
    #3 rst = 1'b1;
    #1;
    chk("fault_cleared", misalign_fault, 1'b0);
    chk("fault_rst_pc", pc_out, RESET_PC);
    @(negedge clk);
    do_reset(-1);
    wait_valid(10);
    chk("after_fault_pc", pc_out, RESET_PC);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
